mbledhesi1bit: RTL and testbench

One-bit full adder cell for the CPU's ripple-carry ALU datapath. Produces sum and carry-out combinationally from two operand bits and a carry-in, and also provides a one-cycle registered copy of both results for pipelined use. Instantiated once per bit position by the wider adder.

---
 rtl/mbledhesi_pkg.sv | 23 ++
 rtl/mbledhesi1bit_gjysmembledhesi.sv | 22 ++
 rtl/mbledhesi1bit.sv | 87 ++++++++
 tb/tb_mbledhesi1bit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mbledhesi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mbledhesi_pkg
// Description : Shared types and constants for the one-bit full adder cell.
//               Holds the reset values of the registered sum/carry pair and
//               the packed struct used to carry that pair as one value.
// Revision    : 1.0  initial release
// ============================================================================
package mbledhesi_pkg;

    // Values the registered outputs take while reset is asserted.
    localparam logic RST_S_VAL    = 1'b0;
    localparam logic RST_COUT_VAL = 1'b0;

    // Registered result pair; cout is the more significant bit so the packed
    // value reads directly as the 2-bit arithmetic sum A+B+CIN.
    typedef struct packed {
        logic cout;
        logic s;
    } sum_carry_t;

endpackage : mbledhesi_pkg
`default_nettype wire

// File: rtl/mbledhesi1bit_gjysmembledhesi.sv
`default_nettype none
// ============================================================================
// Module      : gjysmembledhesi
// Description : Half adder. sum = x XOR y, carry = x AND y. Purely
//               combinational.
// Ports       : x, y   - operand bits
//               sum    - x XOR y
//               carry  - x AND y
// Revision    : 1.0  initial release
// ============================================================================
module gjysmembledhesi (
    input  logic x,
    input  logic y,
    output logic sum,
    output logic carry
);

    assign sum   = x ^ y;
    assign carry = x & y;

endmodule : gjysmembledhesi
`default_nettype wire

// File: rtl/mbledhesi1bit.sv
`default_nettype none
// ============================================================================
// Module      : mbledhesi1bit
// Description : One-bit full adder cell for the ripple-carry ALU datapath.
//               Combinational sum/carry-out plus a one-cycle registered copy
//               of both. Built from two half adders and an OR of their
//               carries.
// Ports       : CLK     - clock, registers update on rising edge
//               RST_N   - asynchronous active-low reset (clears S_Q/COUT_Q)
//               A, B    - operand bits
//               CIN     - carry-in from the less-significant bit
//               S, COUT - combinational sum / carry-out
//               S_Q, COUT_Q - S / COUT registered on CLK
//               P, G    - propagate (A^B) / generate (A&B), only when
//                         MBLEDHESI1BIT_PG_EN is defined
// Config      : MBLEDHESI1BIT_PG_EN - exposes P/G for a carry-lookahead unit
// Revision    : 1.0  initial release
// ============================================================================
module mbledhesi1bit
    import mbledhesi_pkg::*;
(
    input  logic CLK,
    input  logic RST_N,
    input  logic A,
    input  logic B,
    input  logic CIN,
    output logic S,
    output logic COUT,
    output logic S_Q,
    output logic COUT_Q
`ifdef MBLEDHESI1BIT_PG_EN
    ,
    output logic P,
    output logic G
`endif
);

    logic       w_p;     // first stage sum   = A ^ B (propagate)
    logic       w_g;     // first stage carry = A & B (generate)
    logic       w_s;     // second stage sum  = A ^ B ^ CIN
    logic       w_c1;    // second stage carry = CIN & (A ^ B)
    sum_carry_t sc_d;
    sum_carry_t sc_q;

    gjysmembledhesi u_ha0 (
        .x     (A),
        .y     (B),
        .sum   (w_p),
        .carry (w_g)
    );

    gjysmembledhesi u_ha1 (
        .x     (w_p),
        .y     (CIN),
        .sum   (w_s),
        .carry (w_c1)
    );

    // The two half-adder carries can never both be 1, so OR is exact.
    assign S    = w_s;
    assign COUT = w_g | w_c1;

`ifdef MBLEDHESI1BIT_PG_EN
    assign P = w_p;
    assign G = w_g;
`endif

    always_comb begin
        sc_d      = '0;
        sc_d.s    = w_s;
        sc_d.cout = COUT;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sc_q.s    <= RST_S_VAL;
            sc_q.cout <= RST_COUT_VAL;
        end else begin
            sc_q <= sc_d;
        end
    end

    assign S_Q    = sc_q.s;
    assign COUT_Q = sc_q.cout;

endmodule : mbledhesi1bit
`default_nettype wire

// File: tb/tb_mbledhesi1bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mbledhesi1bit
// Description : Self-checking bench for mbledhesi1bit. Expected values come
//               from the arithmetic sum A+B+CIN; registered expectations are
//               the sum of the inputs present before the last rising edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mbledhesi1bit;

    logic CLK;
    logic RST_N;
    logic A;
    logic B;
    logic CIN;
    logic S;
    logic COUT;
    logic S_Q;
    logic COUT_Q;
`ifdef MBLEDHESI1BIT_PG_EN
    logic P;
    logic G;
`endif

    logic clk_en;
    int   pass_cnt;
    int   total_cnt;

    mbledhesi1bit dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .A      (A),
        .B      (B),
        .CIN    (CIN),
        .S      (S),
        .COUT   (COUT),
        .S_Q    (S_Q),
        .COUT_Q (COUT_Q)
`ifdef MBLEDHESI1BIT_PG_EN
        ,
        .P      (P),
        .G      (G)
`endif
    );

    initial CLK = 1'b0;
    always begin
        #5;
        if (clk_en) CLK = ~CLK;
    end

    // Reference model: 2-bit arithmetic sum {cout, s}.
    function automatic logic [1:0] model_sum(input logic a, input logic b, input logic c);
        int v;
        v = int'(a) + int'(b) + int'(c);
        return v[1:0];
    endfunction

    task automatic drive(input logic [2:0] v);
        A   = v[2];
        B   = v[1];
        CIN = v[0];
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] got;
        RST_N = 1'b0;
        drive(3'b111);
        tick();
        got = {COUT_Q, S_Q};
        total_cnt++;
        if (got !== 2'b00) $display("FAIL reset_state: got %b expected 00", got);
        else pass_cnt++;
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_comb_exhaustive();
        logic [1:0] got;
        logic [1:0] exp;
        clk_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            drive(v);
            #1;
            got = {COUT, S};
            exp = model_sum(v[2], v[1], v[0]);
            total_cnt++;
            if (got !== exp) $display("FAIL comb_%0d: {COUT,S} got %b expected %b", i, got, exp);
            else pass_cnt++;
        end
        clk_en = 1'b1;
    endtask

    task automatic test_latency();
        logic [1:0] got;
        drive(3'b000);
        tick();
        drive(3'b111);
        #1;
        got = {COUT_Q, S_Q};
        total_cnt++;
        if (got !== 2'b00) $display("FAIL latency_before: got %b expected 00", got);
        else pass_cnt++;
        tick();
        got = {COUT_Q, S_Q};
        total_cnt++;
        if (got !== 2'b11) $display("FAIL latency_after: got %b expected 11", got);
        else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        logic [1:0] got;
        // Registers hold 11 from the previous task; assert reset between edges.
        #2;
        RST_N = 1'b0;
        #1;
        got = {COUT_Q, S_Q};
        total_cnt++;
        if (got !== 2'b00) $display("FAIL reset_async: got %b expected 00", got);
        else pass_cnt++;
        got = {COUT, S};
        total_cnt++;
        if (got !== 2'b11) $display("FAIL reset_comb_unaffected: got %b expected 11", got);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            got = {COUT_Q, S_Q};
            total_cnt++;
            if (got !== 2'b00) $display("FAIL reset_hold_%0d: got %b expected 00", i, got);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_release();
        logic [1:0] got;
        drive(3'b011);
        #2;
        RST_N = 1'b1;
        tick();
        got = {COUT_Q, S_Q};
        total_cnt++;
        if (got !== 2'b10) $display("FAIL reset_release: {COUT_Q,S_Q} got %b expected 10", got);
        else pass_cnt++;
    endtask

`ifdef MBLEDHESI1BIT_PG_EN
    task automatic test_pg();
        logic [1:0] got;
        for (int c = 0; c < 2; c++) begin
            A = 1'b1; B = 1'b0; CIN = c[0];
            #1;
            got = {P, G};
            total_cnt++;
            if (got !== 2'b10) $display("FAIL pg_10_cin%0d: {P,G} got %b expected 10", c, got);
            else pass_cnt++;
            A = 1'b1; B = 1'b1;
            #1;
            got = {P, G};
            total_cnt++;
            if (got !== 2'b01) $display("FAIL pg_11_cin%0d: {P,G} got %b expected 01", c, got);
            else pass_cnt++;
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [1:0] got;
        logic [1:0] prev_exp;
        drive(3'b000);
        tick();
        prev_exp = 2'b00;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(7 - i);
            drive(v);
            #1;
            // Before the edge the register still holds the previous vector.
            got = {COUT_Q, S_Q};
            total_cnt++;
            if (got !== prev_exp) $display("FAIL b2b_pre_%0d: got %b expected %b", i, got, prev_exp);
            else pass_cnt++;
            tick();
            prev_exp = model_sum(v[2], v[1], v[0]);
            got = {COUT_Q, S_Q};
            total_cnt++;
            if (got !== prev_exp) $display("FAIL b2b_post_%0d: got %b expected %b", i, got, prev_exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [1:0] got;
        logic [1:0] exp_q;
        logic [1:0] exp_c;
        logic [2:0] v;
        v = 3'($urandom_range(0, 7));
        drive(v);
        tick();
        exp_q = model_sum(v[2], v[1], v[0]);
        for (int i = 0; i < 40; i++) begin
            v = 3'($urandom_range(0, 7));
            drive(v);
            #1;
            exp_c = model_sum(v[2], v[1], v[0]);
            got = {COUT, S};
            total_cnt++;
            if (got !== exp_c) $display("FAIL rand_comb_%0d: got %b expected %b", i, got, exp_c);
            else pass_cnt++;
            tick();
            exp_q = exp_c;
            got = {COUT_Q, S_Q};
            total_cnt++;
            if (got !== exp_q) $display("FAIL rand_reg_%0d: got %b expected %b", i, got, exp_q);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        clk_en    = 1'b1;
        RST_N     = 1'b0;
        A         = 1'b0;
        B         = 1'b0;
        CIN       = 1'b0;
        test_reset();
        test_comb_exhaustive();
        test_latency();
        test_reset_midop();
        test_reset_release();
`ifdef MBLEDHESI1BIT_PG_EN
        test_pg();
`endif
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_mbledhesi1bit
`default_nettype wire
